// File: rtl/sdio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdio_pkg
// Purpose  : Shared SDIO CMD-line constants, field widths, state encoding and
//            CRC7 step function.
// Revision : 1.0
// ============================================================================
package sdio_pkg;

  localparam int c_frame_bits = 48;
  localparam int c_index_w    = 6;
  localparam int c_arg_w      = 32;
  localparam int c_crc_w      = 7;
  localparam int c_body_bits  = c_index_w + c_arg_w;

  // x^7 + x^3 + 1, with the x^7 term implied by the shift-out
  localparam logic [c_crc_w-1:0] c_crc7_poly = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIR  = 3'd1,
    ST_BODY = 3'd2,
    ST_CRC  = 3'd3,
    ST_END  = 3'd4,
    ST_SKIP = 3'd5
  } cmd_state_t;

  function automatic logic [c_crc_w-1:0] crc7_step(input logic [c_crc_w-1:0] crc,
                                                   input logic               b);
    logic fb;
    fb = b ^ crc[c_crc_w-1];
    return {crc[c_crc_w-2:0], 1'b0} ^ (fb ? c_crc7_poly : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdio_crc7.sv
`default_nettype none
// ============================================================================
// Module   : sdio_crc7
// Purpose  : Serial CRC7 generator/checker, one bit per enabled clock.
// Revision : 1.0
// ============================================================================
module sdio_crc7
  import sdio_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_bit,
  output logic [c_crc_w-1:0] o_crc
);

  logic [c_crc_w-1:0] r_crc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc7_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sdio_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : sdio_cmd_rx
// Purpose  : SDIO CMD-line receiver: frames 48-bit host commands, checks CRC7
//            and end bit, presents index/argument over a valid/ack handshake.
// Revision : 1.0
// ============================================================================
module sdio_cmd_rx
  import sdio_pkg::*;
#(
  parameter int IDLE_BITS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_sd_cmd,
  output logic                 o_busy,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ack,
  output logic [c_index_w-1:0] o_cmd_index,
  output logic [c_arg_w-1:0]   o_cmd_arg,
  output logic                 o_crc_err,
  output logic                 o_end_err,
  output logic                 o_overrun
);

  localparam int         c_idle_cnt_w = (IDLE_BITS > 0) ? $clog2(IDLE_BITS + 1) : 1;
  localparam logic [5:0] c_body_load  = 6'(c_body_bits - 1);
  localparam logic [5:0] c_crc_load   = 6'(c_crc_w - 1);
  localparam logic [5:0] c_skip_load  = 6'(c_frame_bits - 3);

  cmd_state_t               r_state;
  cmd_state_t               w_state_nxt;
  logic                     r_cmd;
  logic [5:0]               r_cnt;
  logic [c_idle_cnt_w-1:0]  r_idle_cnt;
  logic                     w_idle_ok;
  logic [c_body_bits-1:0]   r_body;
  logic [c_crc_w-1:0]       r_crc_rx;
  logic [c_crc_w-1:0]       w_crc;
  logic                     w_crc_clr;
  logic                     w_crc_en;

  logic                     r_busy;
  logic                     r_valid;
  logic [c_index_w-1:0]     r_index;
  logic [c_arg_w-1:0]       r_arg;
  logic                     r_crc_err;
  logic                     r_end_err;
  logic                     r_overrun;

  // Pad flop: the FSM runs one cycle behind the wire, which places the output
  // latch one cycle after the end-bit sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cmd <= 1'b1;
    else      r_cmd <= i_sd_cmd;
  end

  assign w_idle_ok = (int'(r_idle_cnt) >= IDLE_BITS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (!r_cmd && w_idle_ok) w_state_nxt = ST_DIR;
        ST_DIR:  w_state_nxt = r_cmd ? ST_BODY : ST_SKIP;
        ST_BODY: if (r_cnt == '0) w_state_nxt = ST_CRC;
        ST_CRC:  if (r_cnt == '0) w_state_nxt = ST_END;
        ST_END:  w_state_nxt = ST_IDLE;
        ST_SKIP: if (r_cnt == '0) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_DIR:  r_cnt <= r_cmd ? c_body_load : c_skip_load;
        ST_BODY: r_cnt <= (r_cnt == '0) ? c_crc_load : r_cnt - 6'd1;
        ST_CRC,
        ST_SKIP: if (r_cnt != '0) r_cnt <= r_cnt - 6'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Consecutive idle ones seen in IDLE; saturates once the gap is satisfied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt <= '0;
    end else if (r_state != ST_IDLE || !r_cmd) begin
      r_idle_cnt <= '0;
    end else if (int'(r_idle_cnt) < IDLE_BITS) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_body   <= '0;
      r_crc_rx <= '0;
    end else begin
      if (r_state == ST_BODY) r_body   <= {r_body[c_body_bits-2:0], r_cmd};
      if (r_state == ST_CRC)  r_crc_rx <= {r_crc_rx[c_crc_w-2:0], r_cmd};
    end
  end

  // Cleared throughout IDLE: the zero start bit leaves a zero CRC unchanged.
  assign w_crc_clr = (r_state == ST_IDLE);
  assign w_crc_en  = (r_state == ST_DIR) || (r_state == ST_BODY);

  sdio_crc7 u_crc7 (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (r_cmd),
    .o_crc (w_crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_index   <= '0;
      r_arg     <= '0;
      r_crc_err <= 1'b0;
      r_end_err <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_enable && r_state == ST_END) begin
      r_valid   <= 1'b1;
      r_index   <= r_body[c_body_bits-1:c_arg_w];
      r_arg     <= r_body[c_arg_w-1:0];
      r_crc_err <= (w_crc != r_crc_rx);
      r_end_err <= ~r_cmd;
      if (r_valid && !i_cmd_ack) r_overrun <= 1'b1;
    end else if (r_valid && i_cmd_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign o_busy      = r_busy;
  assign o_cmd_valid = r_valid;
  assign o_cmd_index = r_index;
  assign o_cmd_arg   = r_arg;
  assign o_crc_err   = r_crc_err;
  assign o_end_err   = r_end_err;
  assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sdio_cmd_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sdio_cmd_rx
// Purpose  : Scoreboard bench for sdio_cmd_rx using directed CMD-line frames.
// Revision : 1.0
// ============================================================================
module tb_sdio_cmd_rx;

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic        i_sd_cmd;
  logic        o_busy;
  logic        o_cmd_valid;
  logic        i_cmd_ack;
  logic [5:0]  o_cmd_index;
  logic [31:0] o_cmd_arg;
  logic        o_crc_err;
  logic        o_end_err;
  logic        o_overrun;

  sdio_cmd_rx u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .i_sd_cmd    (i_sd_cmd),
    .o_busy      (o_busy),
    .o_cmd_valid (o_cmd_valid),
    .i_cmd_ack   (i_cmd_ack),
    .o_cmd_index (o_cmd_index),
    .o_cmd_arg   (o_cmd_arg),
    .o_crc_err   (o_crc_err),
    .o_end_err   (o_end_err),
    .o_overrun   (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [47:0] c_cmd0     = 48'h40_0000_0000_95;
  localparam logic [47:0] c_cmd8     = 48'h48_0000_01AA_87;
  localparam logic [47:0] c_cmd8_bad = 48'h48_0000_01AA_85;
  localparam logic [47:0] c_cmd0_eb  = 48'h40_0000_0000_94;
  localparam logic [47:0] c_dev_tok  = 48'h00_0000_0000_01;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc_err;
    logic        end_err;
    logic        ovr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input logic [5:0] idx, input logic [31:0] arg,
                              input logic ce, input logic ee, input logic ov);
    exp_t e;
    e.idx = idx; e.arg = arg; e.crc_err = ce; e.end_err = ee; e.ovr = ov;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted command (valid && ack) is compared to the queue head.
  always @(negedge clk) begin
    if (rst && o_cmd_valid && i_cmd_ack) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got index %0d arg 0x%0h, expected no command",
                 o_cmd_index, o_cmd_arg);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_index",   64'(o_cmd_index), 64'(mon_e.idx));
        check("sb_arg",     64'(o_cmd_arg),   64'(mon_e.arg));
        check("sb_crc_err", 64'(o_crc_err),   64'(mon_e.crc_err));
        check("sb_end_err", 64'(o_end_err),   64'(mon_e.end_err));
        check("sb_overrun", 64'(o_overrun),   64'(mon_e.ovr));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_sd_cmd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      i_sd_cmd = f[i];
      tick();
    end
    i_sd_cmd = 1'b1;
  endtask

  task automatic ack_one(input string name);
    i_cmd_ack = 1'b1;
    tick();
    i_cmd_ack = 1'b0;
    check(name, 64'(o_cmd_valid), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_valid"},   64'(o_cmd_valid), 64'd0);
    check({tag, "_busy"},    64'(o_busy),      64'd0);
    check({tag, "_index"},   64'(o_cmd_index), 64'd0);
    check({tag, "_arg"},     64'(o_cmd_arg),   64'd0);
    check({tag, "_crc_err"}, 64'(o_crc_err),   64'd0);
    check({tag, "_end_err"}, 64'(o_end_err),   64'd0);
    check({tag, "_overrun"}, 64'(o_overrun),   64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    i_enable  = 1'b1;
    i_sd_cmd  = 1'b1;
    i_cmd_ack = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b1;
    idle(8);

    // CMD0 with latency check: valid must appear on the 48th edge after the start bit
    sb_q.push_back(mk(6'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    send_frame(c_cmd0);
    check("cmd0_valid_edge47", 64'(o_cmd_valid), 64'd0);
    tick();
    check("cmd0_valid_edge48", 64'(o_cmd_valid), 64'd1);
    check("cmd0_busy_done",    64'(o_busy),      64'd0);
    ack_one("cmd0_valid_drop");

    // CMD8 held for 5 cycles with ack low
    sb_q.push_back(mk(6'd8, 32'h0000_01AA, 1'b0, 1'b0, 1'b0));
    send_frame(c_cmd8);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("cmd8_hold_valid", 64'(o_cmd_valid), 64'd1);
      check("cmd8_hold_index", 64'(o_cmd_index), 64'd8);
      check("cmd8_hold_arg",   64'(o_cmd_arg),   64'h1AA);
      tick();
    end
    ack_one("cmd8_valid_drop");

    // Corrupted CRC and corrupted end bit
    sb_q.push_back(mk(6'd8, 32'h0000_01AA, 1'b1, 1'b0, 1'b0));
    send_frame(c_cmd8_bad);
    tick();
    check("badcrc_flag", 64'(o_crc_err), 64'd1);
    ack_one("badcrc_drop");

    sb_q.push_back(mk(6'd0, 32'h0, 1'b0, 1'b1, 1'b0));
    send_frame(c_cmd0_eb);
    tick();
    check("endbit_flag", 64'(o_end_err), 64'd1);
    ack_one("endbit_drop");

    // Back-to-back with no ack: CMD0 is overwritten by CMD8, overrun sticks
    sb_q.push_back(mk(6'd8, 32'h0000_01AA, 1'b0, 1'b0, 1'b1));
    send_frame(c_cmd0);
    send_frame(c_cmd8);
    tick();
    check("ovr_flag",  64'(o_overrun),   64'd1);
    check("ovr_index", 64'(o_cmd_index), 64'd8);
    ack_one("ovr_drop");

    // Asynchronous reset in the middle of a frame with a command pending
    send_frame(c_cmd0);
    tick();
    check("rstmid_pending", 64'(o_cmd_valid), 64'd1);
    for (int i = 47; i >= 28; i--) begin
      i_sd_cmd = c_cmd8[i];
      tick();
    end
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    i_sd_cmd = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    idle(2);

    // Ack collides with CMD8's latch: CMD0 consumed, CMD8 wins, no overrun
    sb_q.push_back(mk(6'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(6'd8, 32'h0000_01AA, 1'b0, 1'b0, 1'b0));
    send_frame(c_cmd0);
    send_frame(c_cmd8);
    i_cmd_ack = 1'b1;
    tick();
    i_cmd_ack = 1'b0;
    check("coll_valid",   64'(o_cmd_valid), 64'd1);
    check("coll_overrun", 64'(o_overrun),   64'd0);
    check("coll_index",   64'(o_cmd_index), 64'd8);
    check("coll_arg",     64'(o_cmd_arg),   64'h1AA);
    ack_one("coll_drop");

    // Enable dropped at bit 20 of a frame
    for (int i = 47; i >= 28; i--) begin
      i_sd_cmd = c_cmd8[i];
      tick();
    end
    check("abort_busy_before", 64'(o_busy), 64'd1);
    i_enable = 1'b0;
    i_sd_cmd = c_cmd8[27];
    tick();
    check("abort_busy_after", 64'(o_busy), 64'd0);
    for (int i = 26; i >= 0; i--) begin
      i_sd_cmd = c_cmd8[i];
      tick();
    end
    idle(3);
    i_enable = 1'b1;
    idle(3);
    check("abort_no_valid", 64'(o_cmd_valid), 64'd0);

    // Device-to-host token skipped, then CMD0 directly behind it
    send_frame(c_dev_tok);
    check("skip_no_valid", 64'(o_cmd_valid), 64'd0);
    sb_q.push_back(mk(6'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    send_frame(c_cmd0);
    tick();
    check("skip_then_cmd0_valid", 64'(o_cmd_valid), 64'd1);
    ack_one("skip_then_cmd0_drop");

    idle(4);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
